// File: rtl/eip_seq_pkg.sv
// EIP sequencer shared encodings: FSM states, EIP register commands
// and the instruction-length step helper.
package eip_seq_pkg;

  localparam logic [2:0] INIT   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] UPDATE = 3'd3;
  localparam logic [2:0] HALT   = 3'd4;

  localparam logic [3:0] CMD_IDLE      = 4'h0;
  localparam logic [3:0] CMD_WRITE_EIP = 4'h4;

  // A zero length would stall the sequencer, so it advances by one.
  function automatic logic [31:0] len_step(
    input logic [2:0] len
  );
    return (len == 3'd0) ? 32'd1 : {29'd0, len};
  endfunction

endpackage

// File: rtl/eip_next_calc.sv
// Next-EIP selection: sequential step, jump target, or (with
// EIP_SEQ_IRQ_EN) the interrupt vector, which wins over both.
module eip_next_calc
  import eip_seq_pkg::*;
#(
`ifdef EIP_SEQ_IRQ_EN
  parameter logic [31:0] IRQ_VECTOR = 32'h00000008
`endif
) (
  input  logic [31:0] i_eip,
  input  logic [2:0]  i_len,
  input  logic        i_jump,
  input  logic [31:0] i_target,
`ifdef EIP_SEQ_IRQ_EN
  input  logic        i_irq,
`endif
  output logic [31:0] o_next
);

  always_comb begin
    o_next = i_eip + len_step(i_len);
    if (i_jump)
      o_next = i_target;
`ifdef EIP_SEQ_IRQ_EN
    if (i_irq)
      o_next = IRQ_VECTOR;
`endif
  end

endmodule

// File: rtl/eip_sequencer.sv
// EIP sequencer FSM: INIT/FETCH/EXEC/UPDATE/HALT, registered outputs.
// Optional interrupt entry is enabled by defining EIP_SEQ_IRQ_EN.
module eip_sequencer
  import eip_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000
`ifdef EIP_SEQ_IRQ_EN
  ,
  parameter logic [31:0] IRQ_VECTOR   = 32'h00000008
`endif
) (
  input  logic        clock_5,
  input  logic        reset,
  input  logic [31:0] eip,
  output logic        mem_req,
  output logic [31:0] fetch_addr,
  input  logic        mem_ready,
  input  logic [2:0]  insn_len,
  input  logic        exec_done,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        halt_req,
  output logic [3:0]  read_or_write,
  output logic [31:0] write_data,
  output logic [2:0]  state
`ifdef EIP_SEQ_IRQ_EN
  ,
  input  logic        irq,
  output logic        irq_ack
`endif
);

  logic [2:0]  r_state;
  logic        r_mem_req;
  logic [31:0] r_fetch_addr;
  logic [3:0]  r_rw;
  logic [31:0] r_wd;
  logic [2:0]  r_len;
  logic        r_jv;
  logic [31:0] r_jt;
  logic [31:0] w_next;
`ifdef EIP_SEQ_IRQ_EN
  logic        r_ack;
`endif

  eip_next_calc
`ifdef EIP_SEQ_IRQ_EN
  #(.IRQ_VECTOR(IRQ_VECTOR))
`endif
  u_next (
    .i_eip    (eip),
    .i_len    (r_len),
    .i_jump   (r_jv),
    .i_target (r_jt),
`ifdef EIP_SEQ_IRQ_EN
    .i_irq    (irq),
`endif
    .o_next   (w_next)
  );

  // INIT and UPDATE each spend one idle cycle, then one write cycle;
  // r_rw tells the two apart.
  always_ff @(posedge clock_5 or negedge reset) begin
    if (!reset) begin
      r_state      <= INIT;
      r_mem_req    <= 1'b0;
      r_fetch_addr <= '0;
      r_rw         <= CMD_IDLE;
      r_wd         <= '0;
      r_len        <= '0;
      r_jv         <= 1'b0;
      r_jt         <= '0;
`ifdef EIP_SEQ_IRQ_EN
      r_ack        <= 1'b0;
`endif
    end else begin
      r_rw      <= CMD_IDLE;
      r_mem_req <= 1'b0;
`ifdef EIP_SEQ_IRQ_EN
      r_ack     <= 1'b0;
`endif
      unique case (r_state)
        INIT: begin
          if (r_rw == CMD_IDLE) begin
            r_rw <= CMD_WRITE_EIP;
            r_wd <= RESET_VECTOR;
          end else begin
            r_state      <= FETCH;
            r_mem_req    <= 1'b1;
            r_fetch_addr <= r_wd;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            r_len   <= insn_len;
            r_state <= EXEC;
          end else begin
            r_mem_req    <= 1'b1;
            r_fetch_addr <= eip;
          end
        end
        EXEC: begin
          if (exec_done) begin
            r_jv    <= jump_valid;
            r_jt    <= jump_target;
            r_state <= UPDATE;
          end
        end
        UPDATE: begin
          if (r_rw == CMD_IDLE) begin
            r_rw  <= CMD_WRITE_EIP;
            r_wd  <= w_next;
`ifdef EIP_SEQ_IRQ_EN
            r_ack <= irq;
`endif
          end else if (halt_req) begin
            r_state <= HALT;
          end else begin
            r_state      <= FETCH;
            r_mem_req    <= 1'b1;
            r_fetch_addr <= r_wd;
          end
        end
        HALT: begin
`ifdef EIP_SEQ_IRQ_EN
          if (irq) begin
            r_rw    <= CMD_WRITE_EIP;
            r_wd    <= IRQ_VECTOR;
            r_ack   <= 1'b1;
            r_state <= INIT;
          end else
`endif
          if (!halt_req) begin
            r_state      <= FETCH;
            r_mem_req    <= 1'b1;
            r_fetch_addr <= eip;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign state         = r_state;
  assign mem_req       = r_mem_req;
  assign fetch_addr    = r_fetch_addr;
  assign read_or_write = r_rw;
  assign write_data    = r_wd;
`ifdef EIP_SEQ_IRQ_EN
  assign irq_ack       = r_ack;
`endif

endmodule
